// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_loader_pkg;

    localparam int ADDR_SIZE_DEFAULT  = 8;
    localparam int RESET_HOLD_DEFAULT = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HOLD,
        RUN,
        HALT
    } state_e;

    // Big-endian lane placement: lane 0 lands in [31:24], lane 3 in [7:0].
    function automatic logic [31:0] place_byte(input logic [31:0] base,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] w;
        w = base;
        case (lane)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-wide instruction RAM: one synchronous write port, one combinational read port.
module imem_ram
    import imem_loader_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEFAULT
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [31:0]          wdata,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [31:0]          rdata
);

    logic [31:0] mem_q [2**ADDR_SIZE];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction RAM, then holds the core in reset
// for RESET_HOLD cycles before releasing it; reloads after the core halts.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEFAULT,
    parameter int RESET_HOLD = RESET_HOLD_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    input  logic [31:0]          core_raddr,
    output logic [31:0]          core_instr,
    output logic                 core_reset,
    input  logic                 core_halted,
    output logic                 load_done,
    output logic [ADDR_SIZE:0]   word_count,
    output logic                 overflow_err
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    state_e               state_q, state_d;
    logic [1:0]           lane_q, lane_d;
    logic [31:0]          word_q, word_d;
    logic [ADDR_SIZE:0]   wc_q, wc_d;
    logic                 ovf_q, ovf_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;

    logic                 accept, fresh, word_end, wr_en;
    logic [1:0]           lane_base;
    logic [ADDR_SIZE:0]   wc_base;
    logic                 ovf_base;
    logic [31:0]          word_asm;
    logic                 unused_raddr_hi;

    assign in_ready   = (state_q == IDLE) || (state_q == LOAD) || (state_q == HALT);
    assign accept     = in_valid && in_ready;
    // A byte accepted from IDLE/HALT starts a new image, so it sees cleared progress.
    assign fresh      = (state_q == IDLE) || (state_q == HALT);
    assign lane_base  = fresh ? 2'd0 : lane_q;
    assign wc_base    = fresh ? '0 : wc_q;
    assign ovf_base   = fresh ? 1'b0 : ovf_q;
    assign word_asm   = place_byte((lane_base == 2'd0) ? 32'd0 : word_q, lane_base, in_data);
    assign word_end   = accept && ((lane_base == 2'd3) || in_last);
    assign wr_en      = word_end && !wc_base[ADDR_SIZE];

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        wc_d    = wc_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;

        if (accept) begin
            lane_d = lane_base + 2'd1;
            word_d = word_asm;
            wc_d   = wc_base;
            ovf_d  = ovf_base;
            if (word_end) begin
                lane_d = 2'd0;
                if (wc_base[ADDR_SIZE]) begin
                    ovf_d = 1'b1;
                end else begin
                    wc_d = wc_base + {{ADDR_SIZE{1'b0}}, 1'b1};
                end
            end
        end

        case (state_q)
            IDLE, HALT: begin
                if (accept) begin
                    state_d = in_last ? HOLD : LOAD;
                    hold_d  = '0;
                end
            end
            LOAD: begin
                if (accept && in_last) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                if (int'(hold_q) + 1 >= RESET_HOLD) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (core_halted) begin
                    state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    // Partial-word bytes need no reset: lane 0 always rebuilds from zero.
    always_ff @(posedge clock) begin
        word_q <= word_d;
    end

    imem_ram #(.ADDR_SIZE(ADDR_SIZE)) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wc_base[ADDR_SIZE-1:0]),
        .wdata (word_asm),
        .raddr (core_raddr[ADDR_SIZE-1:0]),
        .rdata (core_instr)
    );

    assign unused_raddr_hi = ^core_raddr[31:ADDR_SIZE];
    assign core_reset      = (state_q == IDLE) || (state_q == LOAD) || (state_q == HOLD);
    assign load_done       = (state_q == RUN) || (state_q == HALT);
    assign word_count      = wc_q;
    assign overflow_err    = ovf_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 8, meaning log2 of word depth (256 x 32-bit words).
REQ-002 SHALL have parameter RESET_HOLD, default 7, meaning cycles core_reset stays high after load completes.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning a program byte is offered.
REQ-006 SHALL have port in_ready, output, 1, meaning the loader accepts the byte this cycle.
REQ-007 SHALL have port in_data, input, 8, meaning the program byte, in image order.
REQ-008 SHALL have port in_last, input, 1, meaning this is the final byte of the image.
REQ-009 SHALL have port core_raddr, input, 32, meaning the core's word-aligned fetch address (pc >> 2).
REQ-010 SHALL have port core_instr, output, 32, meaning the instruction word returned to the core.
REQ-011 SHALL have port core_reset, output, 1, meaning active-high synchronous reset driven to the core.
REQ-012 SHALL have port core_halted, input, 1, meaning the core has executed break.
REQ-013 SHALL have port load_done, output, 1, meaning an image is resident and the core is released.
REQ-014 SHALL have port word_count, output, ADDR_SIZE+1, meaning words written by the current or last load.
REQ-015 SHALL have port overflow_err, output, 1, meaning the image exceeded 2**ADDR_SIZE words.

Function
REQ-016 SHALL implement states IDLE, LOAD, HOLD, RUN and HALT.
REQ-017 SHALL transition as follows:
- IDLE->LOAD on the first accepted byte.
- LOAD->HOLD on the accepted byte with in_last=1.
- HOLD->RUN after RESET_HOLD cycles.
- RUN->HALT when core_halted=1.
- HALT->LOAD on an accepted byte.
REQ-018 SHALL drive in_ready=1 in IDLE, LOAD and HALT, and 0 in HOLD and RUN; a byte is accepted only when in_valid and in_ready are both 1.
REQ-019 SHALL assemble bytes big-endian: byte 0 of each group of four goes to [31:24], byte 3 to [7:0].
REQ-020 SHALL write the assembled word at the edge its 4th byte is accepted, to address word_count, then increment word_count; the word is readable on core_instr from the next cycle.
REQ-021 SHALL, when in_last arrives mid-word, zero-fill the remaining bytes and write the word at that same edge.
REQ-022 SHALL drop words whose index is at or above 2**ADDR_SIZE, set overflow_err, saturate word_count at 2**ADDR_SIZE, and keep in_ready=1 until in_last.
REQ-023 SHALL clear word_count, overflow_err and the byte lane index when a byte is accepted while in IDLE or HALT.
REQ-024 SHALL drive core_instr combinationally as mem[core_raddr[ADDR_SIZE-1:0]], ignoring the upper bits, with zero latency in every state.
REQ-025 SHALL drive core_reset=1 in IDLE, LOAD and HOLD, and 0 in RUN and HALT.
REQ-026 SHALL drive load_done=1 only in RUN and HALT.
REQ-027 SHALL treat in_valid with in_ready=0 as a no-op; the byte is neither consumed nor buffered.

Reset
REQ-028 SHALL, on reset_n=0, immediately enter IDLE with core_reset=1, load_done=0, word_count=0, overflow_err=0, lane=0 and hold counter=0.
REQ-029 SHALL leave memory contents unreset.
REQ-030 SHALL, when reset asserts mid-LOAD, discard the partial word; a word already written stays in memory.

Structure
REQ-031 SHALL place the state enum, ADDR_SIZE default and RESET_HOLD default in shared package imem_loader_pkg.
REQ-032 SHALL instantiate one sub-module, imem_ram: 1 write port, 1 combinational read port, no reset.

Verification
REQ-033 SHALL cover a normal load: 8 bytes 20,02,00,05,00,00,00,0D (last on the 8th) -> mem[0]=0x20020005, mem[1]=0x0000000D, word_count=2, core_reset falls exactly 7 cycles after the last byte, load_done=1.
REQ-034 SHALL cover a partial final word: 5 bytes AA,BB,CC,DD,EE (last) -> mem[1]=0xEE000000, word_count=2.
REQ-035 SHALL cover backpressure: in_valid held during RUN -> in_ready=0 and no memory write; core_halted=1 -> HALT and in_ready=1; a new byte -> LOAD, core_reset=1, word_count=0.
REQ-036 SHALL cover overflow: 1028 bytes with ADDR_SIZE=8 -> overflow_err=1, word_count=256, mem[0] is not overwritten by word 256.
REQ-037 SHALL cover reset mid-load: reset_n low after 6 bytes -> IDLE, word_count=0, mem[0] retained; the next load restarts at address 0.
REQ-038 SHALL cover the read path: core_raddr=0x00000101 with ADDR_SIZE=8 -> core_instr=mem[1].
